hist_accum_ctrl: RTL and testbench

HIST_ACCUM_CTRL -- requirements
Module: hist_accum_ctrl

---
 rtl/hist_accum_ctrl.sv | 115 +++++++++++
 tb/tb_hist_accum_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hist_accum_ctrl.sv
// Histogram job controller: clears 256 bins, streams N pixels through a 2-stage
// read-modify-write pipeline (II=1), drains, pulses done. Host reads bins when idle.
module hist_accum_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [12:0] num_pixels,
  output logic        busy,
  output logic        done,
  output logic [11:0] img_raddr,
  input  logic [7:0]  img_rdata,
  output logic [7:0]  bin_raddr,
  input  logic [31:0] bin_rdata,
  output logic [7:0]  bin_waddr,
  output logic [31:0] bin_wdata,
  output logic        bin_wen,
  input  logic        host_req,
  input  logic [7:0]  host_raddr,
  output logic        host_gnt,
  output logic [31:0] host_rdata
);

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DRAIN} state_t;

  state_t      state;
  logic [12:0] n_q;
  logic [12:0] cnt;
  logic        s1_vld;
  logic        s2_vld;
  logic [7:0]  s2_bin;
  logic        fwd_vld;
  logic [7:0]  fwd_bin;
  logic [31:0] fwd_dat;
  logic [31:0] cur_count;
  logic        clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      n_q     <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s2_bin  <= '0;
      fwd_vld <= 1'b0;
      fwd_bin <= '0;
      fwd_dat <= '0;
    end else begin
      done    <= 1'b0;
      s1_vld  <= (state == ACCUM);
      s2_vld  <= s1_vld;
      s2_bin  <= img_rdata;
      // Only stage-2 writes feed the forward register; clear writes never do.
      fwd_vld <= s2_vld;
      fwd_bin <= s2_bin;
      fwd_dat <= bin_wdata;
      case (state)
        IDLE: begin
          if (start) begin
            n_q   <= (num_pixels > 13'd4096) ? 13'd4096 : num_pixels;
            cnt   <= '0;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          if (cnt == 13'd255) begin
            cnt <= '0;
            if (n_q == 13'd0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end else begin
            cnt <= cnt + 13'd1;
          end
        end
        ACCUM: begin
          if (cnt == n_q - 13'd1) begin
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt <= cnt + 13'd1;
          end
        end
        DRAIN: begin
          if (cnt == 13'd1) begin
            cnt   <= '0;
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 13'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign clr  = (state == CLEAR);
  assign busy = (state != IDLE);

  // The memory returns stale data when the previous cycle wrote the same bin.
  assign cur_count = (fwd_vld && (fwd_bin == s2_bin)) ? fwd_dat : bin_rdata;

  assign img_raddr  = (state == ACCUM) ? cnt[11:0] : 12'd0;
  assign host_gnt   = host_req && (state == IDLE) && !start && !rst;
  assign bin_raddr  = s1_vld ? img_rdata : (host_gnt ? host_raddr : 8'd0);
  assign bin_wen    = !rst && (clr || s2_vld);
  assign bin_waddr  = clr ? cnt[7:0] : (s2_vld ? s2_bin : 8'd0);
  assign bin_wdata  = s2_vld ? cur_count + 32'd1 : 32'd0;
  assign host_rdata = bin_rdata;

endmodule

// File: tb/tb_hist_accum_ctrl.sv
// Directed bench for hist_accum_ctrl with behavioural image/bin memories.
module tb_hist_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [12:0] num_pixels = '0;
  logic        busy, done;
  logic [11:0] img_raddr;
  logic [7:0]  img_rdata;
  logic [7:0]  bin_raddr;
  logic [31:0] bin_rdata;
  logic [7:0]  bin_waddr;
  logic [31:0] bin_wdata;
  logic        bin_wen;
  logic        host_req = 1'b0;
  logic [7:0]  host_raddr = '0;
  logic        host_gnt;
  logic [31:0] host_rdata;

  logic [7:0]  img_mem [4096];
  logic [31:0] bin_mem [256];
  logic        load_mem = 1'b0;
  logic [31:0] cur_pat = '0;

  int n_vec = 0;
  int n_fail = 0;

  hist_accum_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_pixels(num_pixels),
    .busy(busy), .done(done), .img_raddr(img_raddr), .img_rdata(img_rdata),
    .bin_raddr(bin_raddr), .bin_rdata(bin_rdata), .bin_waddr(bin_waddr),
    .bin_wdata(bin_wdata), .bin_wen(bin_wen), .host_req(host_req),
    .host_raddr(host_raddr), .host_gnt(host_gnt), .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input logic [31:0] pat, input int k);
    logic [31:0] t;
    t = pat >> (8 * (k % 4));
    return t[7:0];
  endfunction

  // Synchronous-read memories; a read colliding with a write returns old data.
  always @(posedge clk) begin
    img_rdata <= img_mem[img_raddr];
    bin_rdata <= bin_mem[bin_raddr];
    if (load_mem) begin
      for (int i = 0; i < 4096; i++) img_mem[i] <= pix(cur_pat, i);
      for (int i = 0; i < 256; i++) bin_mem[i] <= $urandom;
    end else if (bin_wen) begin
      bin_mem[bin_waddr] <= bin_wdata;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int          n;
    logic [31:0] pat;
    int          exp_done;
    int          exp_busy;
    int          bin_a;
    int          cnt_a;
    int          bin_b;
    int          cnt_b;
  } job_t;

  job_t jobs[6];

  task automatic load_memories(input logic [31:0] pat);
    @(negedge clk);
    cur_pat  = pat;
    load_mem = 1'b1;
    @(negedge clk);
    load_mem = 1'b0;
  endtask

  task automatic run_job(input job_t j);
    int nc, cyc, done_cyc, busy_cnt, img_err, clr_err, w_err, gnt_err, hist_err, exp_img;
    int run[256];
    int hist[256];
    logic exp_wen;
    logic [7:0] p;
    nc = (j.n > 4096) ? 4096 : j.n;
    for (int i = 0; i < 256; i++) begin run[i] = 0; hist[i] = 0; end
    load_memories(j.pat);
    start = 1'b1;
    num_pixels = j.n[12:0];
    host_req = 1'b1;
    host_raddr = 8'hAA;
    #1;
    check("gnt_vs_start", host_gnt, 0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    num_pixels = '0;
    cyc = 1; done_cyc = -1; busy_cnt = 0;
    img_err = 0; clr_err = 0; w_err = 0; gnt_err = 0;
    while (cyc < 5000 && done_cyc < 0) begin
      if (busy) busy_cnt++;
      if (busy && host_gnt) gnt_err++;
      if (done) done_cyc = cyc;
      exp_img = (cyc >= 257 && cyc <= 256 + nc) ? cyc - 257 : 0;
      if (int'(img_raddr) != exp_img) img_err++;
      if (cyc <= 256) begin
        if (!bin_wen || int'(bin_waddr) != cyc - 1 || bin_wdata != 32'd0) clr_err++;
      end else begin
        exp_wen = (cyc >= 259 && cyc <= nc + 258);
        if (bin_wen != exp_wen) w_err++;
        else if (exp_wen) begin
          p = pix(j.pat, cyc - 259);
          if (bin_waddr != p || bin_wdata != 32'(run[p] + 1)) w_err++;
          run[p]++;
        end
      end
      if (done_cyc < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    host_req = 1'b0;
    check("done_cycle", done_cyc, j.exp_done);
    check("busy_cycles", busy_cnt, j.exp_busy);
    check("img_addr_errs", img_err, 0);
    check("clear_errs", clr_err, 0);
    check("accum_write_errs", w_err, 0);
    check("gnt_while_busy", gnt_err, 0);
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("idle_wen", bin_wen, 0);
    for (int k = 0; k < nc; k++) hist[pix(j.pat, k)]++;
    hist_err = 0;
    for (int b = 0; b < 256; b++) if (bin_mem[b] != 32'(hist[b])) hist_err++;
    check("hist_errs", hist_err, 0);
    check("bin_a", bin_mem[j.bin_a], j.cnt_a);
    check("bin_b", bin_mem[j.bin_b], j.cnt_b);
  endtask

  task automatic host_read_test();
    @(negedge clk);
    host_req = 1'b1;
    host_raddr = 8'd3;
    #1;
    check("host_gnt_idle", host_gnt, 1);
    check("host_bin_raddr", bin_raddr, 3);
    @(negedge clk);
    host_req = 1'b0;
    check("host_rdata", host_rdata, 2);
  endtask

  task automatic reset_mid_job();
    int bad;
    load_memories(32'h01010101);
    start = 1'b1;
    num_pixels = 13'd100;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 300; c++) @(negedge clk);
    check("busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_wen", bin_wen, 0);
    check("rst_img_raddr", img_raddr, 0);
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (done || bin_wen || busy) bad++;
      @(negedge clk);
    end
    check("post_rst_activity", bad, 0);
  endtask

  initial begin
    jobs[0] = '{n: 4,    pat: 32'h09030703, exp_done: 263,  exp_busy: 262,  bin_a: 3,   cnt_a: 2,    bin_b: 9, cnt_b: 1};
    jobs[1] = '{n: 3,    pat: 32'h05050505, exp_done: 262,  exp_busy: 261,  bin_a: 5,   cnt_a: 3,    bin_b: 0, cnt_b: 0};
    jobs[2] = '{n: 0,    pat: 32'h11111111, exp_done: 257,  exp_busy: 256,  bin_a: 17,  cnt_a: 0,    bin_b: 0, cnt_b: 0};
    jobs[3] = '{n: 6,    pat: 32'h04060404, exp_done: 265,  exp_busy: 264,  bin_a: 4,   cnt_a: 5,    bin_b: 6, cnt_b: 1};
    jobs[4] = '{n: 4096, pat: 32'hFFFFFFFF, exp_done: 4355, exp_busy: 4354, bin_a: 255, cnt_a: 4096, bin_b: 0, cnt_b: 0};
    jobs[5] = '{n: 5000, pat: 32'h02010201, exp_done: 4355, exp_busy: 4354, bin_a: 1,   cnt_a: 2048, bin_b: 2, cnt_b: 2048};

    rst = 1'b1;
    host_req = 1'b1;
    host_raddr = 8'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    check("rst_bin_wen0", bin_wen, 0);
    check("rst_host_gnt0", host_gnt, 0);
    check("rst_img_raddr0", img_raddr, 0);
    check("rst_bin_raddr0", bin_raddr, 0);
    check("rst_bin_waddr0", bin_waddr, 0);
    check("rst_bin_wdata0", bin_wdata, 0);
    rst = 1'b0;
    host_req = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (i == 3) reset_mid_job();
      run_job(jobs[i]);
      if (i == 0) host_read_test();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
